ps2_dir_tracker: RTL and testbench

- Sequential successor to the combinational arrow-key decoder.
- Consumes PS/2 set-2 scan-code bytes with a valid strobe and tracks E0 (extended) and F0 (break) prefixes.
- Holds a per-key pressed mask and a one-hot "active direction" (last pressed wins).
- Emits a step pulse on each new press, then repeats it at a fixed rate while the key is held.
- Sits between the PS/2 byte receiver and the VGA object-position logic.

---
 rtl/ps2_dir_tracker.sv | 118 +++++++++++
 tb/tb_ps2_dir_tracker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_dir_tracker.sv
// PS/2 set-2 arrow-key tracker: decodes E0/F0 prefixes, keeps a held-key mask,
// a one-hot active direction (last press wins) and a press/auto-repeat step pulse.
module ps2_dir_tracker #(
  parameter logic [7:0]  CODE_LEFT  = 8'h6B,
  parameter logic [7:0]  CODE_RIGHT = 8'h74,
  parameter logic [7:0]  CODE_UP    = 8'h75,
  parameter logic [7:0]  CODE_DOWN  = 8'h72,
  parameter bit          REQ_EXT    = 1'b1,
  parameter int unsigned STEP_DIV   = 2500000,
  parameter int unsigned CNT_W      = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic [3:0] held,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       step
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  localparam logic [7:0]       PFX_EXT   = 8'hE0;
  localparam logic [7:0]       PFX_BRK   = 8'hF0;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

  state_e           state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [3:0]       dir_q, dir_d;      // one-hot {up,down,left,right}
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;

  logic       is_ext, is_brk, in_ext, in_brk;
  logic       press, fallback, rep_hit;
  logic [3:0] match;

  function automatic logic [3:0] pick_prio(input logic [3:0] h);
    if (h[3])      return 4'b1000;
    else if (h[2]) return 4'b0100;
    else if (h[1]) return 4'b0010;
    else if (h[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    dir_d    = dir_q;
    press    = 1'b0;
    fallback = 1'b0;
    rep_hit  = 1'b0;
    cnt_d    = '0;

    is_ext = (code == PFX_EXT);
    is_brk = (code == PFX_BRK);
    in_ext = (state_q == EXT) || (state_q == EXT_BRK);
    in_brk = (state_q == BRK) || (state_q == EXT_BRK);
    match  = {code == CODE_UP, code == CODE_DOWN, code == CODE_LEFT, code == CODE_RIGHT}
             & {4{in_ext || !REQ_EXT}};

    if (code_valid) begin
      if (is_ext)      state_d = in_brk ? EXT_BRK : EXT;
      else if (is_brk) state_d = in_ext ? EXT_BRK : BRK;
      else             state_d = IDLE;

      if (!is_ext && !is_brk) begin
        if (!in_brk) begin
          held_d = held_q | match;
          // A make of the already-active key is typematic repeat and leaves the grid alone.
          if ((match & ~dir_q) != 4'b0000) begin
            dir_d = match;
            press = 1'b1;
          end
        end else if ((match & held_q) != 4'b0000) begin
          held_d = held_q & ~match;
          if ((match & dir_q) != 4'b0000) begin
            dir_d    = pick_prio(held_q & ~match);
            fallback = 1'b1;
          end
        end
      end
    end

    if (!press && !fallback && dir_q != 4'b0000) begin
      if (cnt_q == STEP_LAST) rep_hit = 1'b1;
      else                    cnt_d   = cnt_q + CNT_W'(1);
    end

    // Back-to-back presses must not produce two adjacent pulses.
    step_d = (press || rep_hit) && !step_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      dir_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign held                    = held_q;
  assign {up, down, left, right} = dir_q;
  assign step                    = step_q;

endmodule

// File: tb/tb_ps2_dir_tracker.sv
// Directed bench for ps2_dir_tracker: one instance with REQ_EXT=1, a twin with
// REQ_EXT=0 fed the same bytes, both with STEP_DIV=4.
module tb_ps2_dir_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;

  logic [3:0] held, held_x;
  logic       left, right, up, down, step;
  logic       left_x, right_x, up_x, down_x, step_x;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_dir_tracker #(.REQ_EXT(1'b1), .STEP_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .held(held), .left(left), .right(right), .up(up), .down(down), .step(step)
  );

  ps2_dir_tracker #(.REQ_EXT(1'b0), .STEP_DIV(4), .CNT_W(3)) dut_x (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .held(held_x), .left(left_x), .right(right_x), .up(up_x), .down(down_x), .step(step_x)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks held mask, {up,down,left,right} and step of the REQ_EXT=1 instance.
  task automatic chk(input string tag, input logic [3:0] eh, input logic [3:0] ed, input logic es);
    check({tag, ".held"}, {4'h0, held}, {4'h0, eh});
    check({tag, ".dir"},  {4'h0, up, down, left, right}, {4'h0, ed});
    check({tag, ".step"}, {7'h0, step}, {7'h0, es});
  endtask

  task automatic chk_x(input string tag, input logic [3:0] eh, input logic [3:0] ed, input logic es);
    check({tag, ".held_x"}, {4'h0, held_x}, {4'h0, eh});
    check({tag, ".dir_x"},  {4'h0, up_x, down_x, left_x, right_x}, {4'h0, ed});
    check({tag, ".step_x"}, {7'h0, step_x}, {7'h0, es});
  endtask

  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Step must stay low for k-1 cycles and pulse on the k-th.
  task automatic expect_step_in(input string tag, input int k);
    for (int i = 1; i <= k; i++) begin
      idle(1);
      check(tag, {7'h0, step}, {7'h0, (i == k)});
    end
  endtask

  initial begin
    #12;
    chk("reset", 4'b0000, 4'b0000, 1'b0);
    chk_x("reset", 4'b0000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Extended left press, then repeat grid.
    send(8'hE0);
    chk("e0_only", 4'b0000, 4'b0000, 1'b0);
    send(8'h6B);
    chk("press_left", 4'b0010, 4'b0010, 1'b1);
    idle(1);
    check("press_one_cycle", {7'h0, step}, 8'h00);
    expect_step_in("rep1", 3);
    expect_step_in("rep2", 4);

    // Release left: everything clears and stays quiet.
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("release_left", 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("quiet_after_release", {7'h0, step}, 8'h00);
    end

    // Left, then up, then release up -> fallback to left.
    send(8'hE0);
    send(8'h6B);
    chk("press_left2", 4'b0010, 4'b0010, 1'b1);
    send(8'hE0);
    send(8'h75);
    chk("press_up", 4'b1010, 4'b1000, 1'b1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("fallback_left", 4'b0010, 4'b0010, 1'b0);
    expect_step_in("after_fallback", 4);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("release_left2", 4'b0000, 4'b0000, 1'b0);

    // Bare make: ignored when E0 is required, accepted otherwise.
    send(8'h6B);
    chk("bare_6b", 4'b0000, 4'b0000, 1'b0);
    chk_x("bare_6b", 4'b0010, 4'b0010, 1'b1);
    send(8'h6B);
    chk("bare_6b_again", 4'b0000, 4'b0000, 1'b0);
    send(8'hF0);
    send(8'h6B);
    chk_x("bare_release", 4'b0000, 4'b0000, 1'b0);
    chk("bare_release", 4'b0000, 4'b0000, 1'b0);

    // Typematic repeats of left every 2 cycles.
    send(8'hE0);
    send(8'h6B);
    chk("typ_press", 4'b0010, 4'b0010, 1'b1);
    send(8'hE0);
    send(8'h6B);
    chk("typ_repeat1", 4'b0010, 4'b0010, 1'b0);
    send(8'hE0);
    send(8'h6B);
    chk("typ_repeat2_grid", 4'b0010, 4'b0010, 1'b1);
    expect_step_in("typ_grid", 4);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("typ_release", 4'b0000, 4'b0000, 1'b0);

    // Reset inside a break sequence discards the pending prefix.
    send(8'hE0);
    send(8'h6B);
    chk("pre_reset_press", 4'b0010, 4'b0010, 1'b1);
    send(8'hE0);
    rst = 1'b1;
    #2;
    chk("async_reset", 4'b0000, 4'b0000, 1'b0);
    chk_x("async_reset", 4'b0000, 4'b0000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'h75);
    chk("post_reset_75", 4'b0000, 4'b0000, 1'b0);
    chk_x("post_reset_75", 4'b1000, 4'b1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
